// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch front end.
// Issues fetches to a 1-cycle-latency synchronous instruction memory.
// Returned words are buffered with their PC in a small FIFO, which is presented
// to decode over a valid/ready handshake.
// A redirect from execute flushes the FIFO and restarts fetch at the new target.
// Optional macro FETCH_PERF_EN adds two 32-bit performance counters:
// perf_fetched and perf_bubbles.
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   output logic        imem_en,
   input  logic [31:0] imem_dout,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] inst_out,
   output logic [31:0] pc_out,
   output logic        valid_out,
   input  logic        ready_in
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_bubbles
`endif
);

   localparam int          PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int          CNT_W    = PTR_W + 1;
   localparam int          OCC_W    = CNT_W + 1;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   logic [31:0]      fetch_pc_reg;
   logic [31:0]      req_pc_reg;
   logic [31:0]      last_pc_reg;
   logic             inflight_reg;
   logic [31:0]      pc_mem   [FIFO_DEPTH];
   logic [31:0]      inst_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [CNT_W-1:0] count_reg;

   logic             fifo_empty;
   logic             deq;
   logic             resp_kill;
   logic             fifo_wr;
   logic [OCC_W-1:0] occupancy;
   logic [31:0]      redirect_target;
   logic             unused_redirect_lsbs;

   // The two low bits of a redirect target are ignored by definition.
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // Handshake, response acceptance and issue decision.
   always_comb begin
      redirect_target = {redirect_pc[31:2], 2'b00};
      fifo_empty      = (count_reg == '0);
      valid_out       = !rst && !redirect_valid && !fifo_empty;
      deq             = valid_out && ready_in;
      // A response landing during a redirect or reset belongs to the abandoned
      // stream, so it is dropped instead of being written.
      resp_kill       = rst || redirect_valid;
      fifo_wr         = inflight_reg && !resp_kill;
      // Slots already committed: buffered words + the word on imem_dout - the word leaving now.
      occupancy       = OCC_W'(count_reg) + OCC_W'(inflight_reg) - OCC_W'(deq);
      imem_en         = !rst && (redirect_valid || (occupancy < OCC_W'(FIFO_DEPTH)));
      imem_addr       = redirect_valid ? redirect_target : fetch_pc_reg;
   end

   // Decode-facing data: the FIFO head, a NOP when empty, and the last PC held while empty.
   always_comb begin
      inst_out = NOP_INST;
      pc_out   = 32'h0000_0000;
      if (!rst) begin
         pc_out = last_pc_reg;
         if (!fifo_empty) begin
            inst_out = inst_mem[rd_ptr_reg];
            pc_out   = pc_mem[rd_ptr_reg];
         end
      end
   end

   // PC tracking: a redirect issues its target this cycle, so next is target + 4.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_reg <= RESET_PC;
         inflight_reg <= 1'b0;
         req_pc_reg   <= RESET_PC;
         last_pc_reg  <= 32'h0000_0000;
      end else begin
         inflight_reg <= imem_en;
         last_pc_reg  <= pc_out;
         if (imem_en) begin
            req_pc_reg   <= imem_addr;
            fetch_pc_reg <= imem_addr + 32'd4;
         end
      end
   end

   // FIFO pointers and count; a redirect empties the buffer at the edge.
   always_ff @(posedge clk) begin
      if (rst || redirect_valid) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (fifo_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (deq)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + CNT_W'(fifo_wr) - CNT_W'(deq);
      end
   end

   // FIFO storage: returned word paired with the PC it was fetched from.
   always_ff @(posedge clk) begin
      if (fifo_wr) begin
         pc_mem[wr_ptr_reg]   <= req_pc_reg;
         inst_mem[wr_ptr_reg] <= imem_dout;
      end
   end

   // The issue rule keeps the FIFO from ever being written while full.
   no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(fifo_wr && !deq && (count_reg == CNT_W'(FIFO_DEPTH))));

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_reg;
   logic [31:0] perf_bubbles_reg;

   // Delivered instructions, and cycles decode was ready but starved.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched_reg <= 32'h0000_0000;
         perf_bubbles_reg <= 32'h0000_0000;
      end else begin
         if (deq)                    perf_fetched_reg <= perf_fetched_reg + 32'd1;
         if (ready_in && !valid_out) perf_bubbles_reg <= perf_bubbles_reg + 32'd1;
      end
   end

   assign perf_fetched = perf_fetched_reg;
   assign perf_bubbles = perf_bubbles_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed table, hand-written sequences and a randomized run
// for fetch_stage.
// Two instances are used: one with the default RESET_PC and one with RESET_PC
// near the top of the address space, so the PC wrap can be observed.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: default parameters.
   logic        rst_a = 1'b1, ready_a = 1'b0, rv_a = 1'b0;
   logic [31:0] rpc_a = '0, dout_a, addr_a, inst_a, pc_a;
   logic        en_a, valid_a;
   logic [31:0] key_a = '0;

   // Instance B: RESET_PC close to the wrap point.
   logic        rst_b = 1'b1, ready_b = 1'b0, rv_b = 1'b0;
   logic [31:0] rpc_b = '0, dout_b, addr_b, inst_b, pc_b;
   logic        en_b, valid_b;

`ifdef FETCH_PERF_EN
   logic [31:0] pf_a, pb_a, pf_b, pb_b;
`endif

   fetch_stage u_a (
      .clk(clk), .rst(rst_a), .imem_addr(addr_a), .imem_en(en_a), .imem_dout(dout_a),
      .redirect_valid(rv_a), .redirect_pc(rpc_a), .inst_out(inst_a), .pc_out(pc_a),
      .valid_out(valid_a), .ready_in(ready_a)
`ifdef FETCH_PERF_EN
      , .perf_fetched(pf_a), .perf_bubbles(pb_a)
`endif
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_b (
      .clk(clk), .rst(rst_b), .imem_addr(addr_b), .imem_en(en_b), .imem_dout(dout_b),
      .redirect_valid(rv_b), .redirect_pc(rpc_b), .inst_out(inst_b), .pc_out(pc_b),
      .valid_out(valid_b), .ready_in(ready_b)
`ifdef FETCH_PERF_EN
      , .perf_fetched(pf_b), .perf_bubbles(pb_b)
`endif
   );

   // Synchronous-read memories. A has word = address ^ key; B has word = address.
   // Garbage is returned when no fetch was issued.
   always @(posedge clk) dout_a <= en_a ? (addr_a ^ key_a) : $urandom;
   always @(posedge clk) dout_b <= en_b ? addr_b : $urandom;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h, expected %08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive_a(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
      @(negedge clk);
      rst_a = r; ready_a = rdy; rv_a = rv; rpc_a = rpc;
      #2;
   endtask

   task automatic drive_b(input logic r, input logic rdy);
      @(negedge clk);
      rst_b = r; ready_b = rdy; rv_b = 1'b0; rpc_b = '0;
      #2;
   endtask

   typedef struct {
      logic        rst;
      logic        ready;
      logic        rv;
      logic [31:0] rpc;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic        exp_en;
      logic [31:0] exp_addr;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                      input logic ev, input logic [31:0] epc, input logic een, input logic [31:0] eaddr);
      vec_t v;
      v.rst = r; v.ready = rdy; v.rv = rv; v.rpc = rpc;
      v.exp_valid = ev; v.exp_pc = epc; v.exp_en = een; v.exp_addr = eaddr;
      tbl.push_back(v);
   endtask

   // Behavioural reference state for the randomized run.
   logic [31:0] exp_pc, exp_fetch;
   int          since, pend;
   int          bf, bb;
   logic        ve, een, d;

   initial begin
      // ---------------- Table: stream, stall, redirects, reset ----------------
      add(1,1,0,0,          0,0,       0,0);
      add(0,1,0,0,          0,0,       1,32'h0);
      add(0,1,0,0,          0,0,       1,32'h4);
      add(0,1,0,0,          1,32'h0,   1,32'h8);
      add(0,1,0,0,          1,32'h4,   1,32'hC);
      add(0,1,0,0,          1,32'h8,   1,32'h10);
      add(0,1,0,0,          1,32'hC,   1,32'h14);
      for (int k = 0; k < 6; k++) add(0,0,0,0, 1,32'h10, 0,0);
      add(0,1,0,0,          1,32'h10,  1,32'h18);
      add(0,1,0,0,          1,32'h14,  1,32'h1C);
      add(0,1,0,0,          1,32'h18,  1,32'h20);
      add(0,1,1,32'h103,    0,0,       1,32'h100);
      add(0,1,0,0,          0,0,       1,32'h104);
      add(0,1,0,0,          1,32'h100, 1,32'h108);
      add(0,1,0,0,          1,32'h104, 1,32'h10C);
      add(0,1,1,32'h200,    0,0,       1,32'h200);
      add(0,1,1,32'h300,    0,0,       1,32'h300);
      add(0,1,0,0,          0,0,       1,32'h304);
      add(0,1,0,0,          1,32'h300, 1,32'h308);
      add(0,1,0,0,          1,32'h304, 1,32'h30C);
      add(1,1,0,0,          0,0,       0,0);
      add(0,1,0,0,          0,0,       1,32'h0);
      add(0,1,0,0,          0,0,       1,32'h4);
      add(0,1,0,0,          1,32'h0,   1,32'h8);

      for (int i = 0; i < tbl.size(); i++) begin
         drive_a(tbl[i].rst, tbl[i].ready, tbl[i].rv, tbl[i].rpc);
         $display("vec %0d: rst=%0b rdy=%0b rv=%0b -> valid=%0b pc=%08h inst=%08h en=%0b addr=%08h",
                  i, tbl[i].rst, tbl[i].ready, tbl[i].rv, valid_a, pc_a, inst_a, en_a, addr_a);
         chk($sformatf("vec%0d valid_out", i), {31'b0, valid_a}, {31'b0, tbl[i].exp_valid});
         chk($sformatf("vec%0d imem_en", i),   {31'b0, en_a},    {31'b0, tbl[i].exp_en});
         if (tbl[i].exp_en) chk($sformatf("vec%0d imem_addr", i), addr_a, tbl[i].exp_addr);
         if (tbl[i].rst) begin
            chk($sformatf("vec%0d reset pc_out", i),   pc_a,   32'h0);
            chk($sformatf("vec%0d reset inst_out", i), inst_a, NOP);
         end else if (tbl[i].exp_valid) begin
            chk($sformatf("vec%0d pc_out", i),   pc_a,   tbl[i].exp_pc);
            chk($sformatf("vec%0d inst_out", i), inst_a, tbl[i].exp_pc);
         end
      end

      // ---------------- Hand-written: PC wrap and mid-stream reset on B ----------------
      drive_a(1,0,0,0);
      drive_b(1,1);
      chk("B reset valid", {31'b0, valid_b}, 32'h0);
      chk("B reset en",    {31'b0, en_b},    32'h0);
      drive_b(0,1); $display("B c1 en=%0b addr=%08h", en_b, addr_b);
      chk("B c1 addr", addr_b, 32'hFFFF_FFF8);
      chk("B c1 valid", {31'b0, valid_b}, 32'h0);
      drive_b(0,1); $display("B c2 en=%0b addr=%08h", en_b, addr_b);
      chk("B c2 addr", addr_b, 32'hFFFF_FFFC);
      drive_b(0,1); $display("B c3 addr=%08h pc=%08h", addr_b, pc_b);
      chk("B c3 addr wrap", addr_b, 32'h0000_0000);
      chk("B c3 valid", {31'b0, valid_b}, 32'h1);
      chk("B c3 pc", pc_b, 32'hFFFF_FFF8);
      drive_b(0,1); $display("B c4 pc=%08h inst=%08h", pc_b, inst_b);
      chk("B c4 pc", pc_b, 32'hFFFF_FFFC);
      chk("B c4 inst", inst_b, 32'hFFFF_FFFC);
      drive_b(0,1); $display("B c5 pc=%08h", pc_b);
      chk("B c5 pc wrap", pc_b, 32'h0000_0000);
      drive_b(1,1); $display("B c6 rst valid=%0b", valid_b);
      chk("B c6 rst valid", {31'b0, valid_b}, 32'h0);
      chk("B c6 rst inst", inst_b, NOP);
      drive_b(0,1); $display("B c7 valid=%0b addr=%08h", valid_b, addr_b);
      chk("B c7 valid after rst", {31'b0, valid_b}, 32'h0);
      chk("B c7 restart addr", addr_b, 32'hFFFF_FFF8);
      drive_b(0,1);
      drive_b(0,1); $display("B c9 valid=%0b pc=%08h", valid_b, pc_b);
      chk("B c9 pc", pc_b, 32'hFFFF_FFF8);
      drive_b(1,0);

`ifdef FETCH_PERF_EN
      // ---------------- Hand-written: performance counters ----------------
      drive_a(1,1,0,0);
      drive_a(0,1,0,0);
      chk("perf fetched cleared", pf_a, 32'd0);
      chk("perf bubbles cleared", pb_a, 32'd0);
      for (int k = 0; k < 11; k++) drive_a(0,1,0,0);
      drive_a(0,1,1,32'h40);
      drive_a(0,0,0,0);
      $display("perf fetched=%0d bubbles=%0d", pf_a, pb_a);
      chk("perf fetched", pf_a, 32'd10);
      chk("perf bubbles", pb_a, 32'd3);
`endif

      // ---------------- Randomized run against the reference model ----------------
      exp_pc = '0; exp_fetch = '0; since = 0; pend = 0; bf = 0; bb = 0;
      for (int c = 0; c < 1500; c++) begin
         logic r, rdy, rv;
         logic [31:0] rpc;
         r   = (c == 0) || ($urandom_range(0, 99) == 0);
         rdy = ($urandom_range(0, 9) < 7);
         rv  = ($urandom_range(0, 19) == 0);
         rpc = $urandom;
         if (c == 0) key_a = $urandom | 32'h0001_0000;
         drive_a(r, rdy, rv, rpc);
         if (r) begin
            chk("rand rst valid", {31'b0, valid_a}, 32'h0);
            chk("rand rst en",    {31'b0, en_a},    32'h0);
            chk("rand rst pc",    pc_a,   32'h0);
            chk("rand rst inst",  inst_a, NOP);
            exp_pc = 32'h0; exp_fetch = 32'h0; since = 0; pend = 0; bf = 0; bb = 0;
         end else begin
            // Output is valid from the second cycle after a restart and never starves after that.
            ve  = !rv && (since >= 2);
            d   = ve && rdy;
            een = rv || ((pend - int'(d)) < 2);
            chk("rand valid_out", {31'b0, valid_a}, {31'b0, ve});
            chk("rand imem_en",   {31'b0, en_a},    {31'b0, een});
            if (rv) chk("rand redirect addr", addr_a, {rpc[31:2], 2'b00});
            else if (een) chk("rand fetch addr", addr_a, exp_fetch);
            if (ve) begin
               chk("rand pc_out",   pc_a,   exp_pc);
               chk("rand inst_out", inst_a, exp_pc ^ key_a);
            end
            if (d) $display("xfer pc=%08h inst=%08h", pc_a, inst_a);
            if (d) bf++;
            if (rdy && !ve) bb++;
            if (rv) begin
               exp_pc    = {rpc[31:2], 2'b00};
               exp_fetch = {rpc[31:2], 2'b00} + 32'd4;
               pend      = 1;
               since     = 1;
            end else begin
               if (d)   exp_pc    = exp_pc + 32'd4;
               if (een) exp_fetch = exp_fetch + 32'd4;
               pend = pend - int'(d) + int'(een);
               if (since < 100) since++;
            end
         end
      end
      drive_a(0,0,0,0);
`ifdef FETCH_PERF_EN
      chk("rand perf fetched", pf_a, bf);
      chk("rand perf bubbles", pb_a, bb);
`endif
      drive_a(1,0,0,0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
